// File: rtl/banked_ram.sv
// -----------------------------------------------------------------------------
// banked_ram
//
// A byte-lane banked RAM that accepts any byte alignment. It is built from
// NBYTE = XLEN/8 independent byte-wide banks. Each access decodes one row
// pointer A. Banks below the byte offset use row A+1, so an unaligned word is
// split across two rows and still completes in a single cycle. Row A+1 wraps
// modulo the number of rows, which means an access at the top of the region
// wraps back to its start.
//
// Read path : valid/ready request, one-cycle registered response with
//             backpressure, and an out-of-range error flag.
// Write path: valid/ready, committed in the cycle it is accepted.
// Host mode : when host_sel_i is high, the host loader address drives both
//             paths and the core ports are stalled. Zero host byte enables
//             mean a host read.
//
// Optional feature, enabled by defining the macro BANKED_RAM_FWD_EN:
//   A read that collides with a write to the same bank and row in the same
//   cycle returns the newly written byte. The selection is made per byte
//   through the write byte enables. Without the macro, a colliding read
//   returns the old memory contents.
//
// Parameters
//   XLEN       data width, 32 or 64
//   ROW_BITS   log2 of the number of rows per bank
//   BASE_ADDR  region base, aligned to the region size (NBYTE << ROW_BITS)
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   host_sel_i            host loader owns both paths
//   host_addr_i           host byte address
//   host_wr_data_i        host write data
//   host_wr_byte_en_i     host byte enables (all zero = host read)
//   rd_valid_i/rd_ready_o read request handshake
//   rd_addr_i             read byte address
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_data_o            response data, byte 0 = byte at the read address
//   rsp_err_o             response address was out of range
//   wr_valid_i/wr_ready_o write request handshake
//   wr_addr_i             write byte address
//   wr_data_i             write data, byte 0 goes to wr_addr_i
//   wr_byte_en_i          byte enables relative to wr_addr_i
// -----------------------------------------------------------------------------
module banked_ram #(
  parameter int          XLEN      = 32,
  parameter int          ROW_BITS  = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              host_sel_i,
  input  logic [XLEN-1:0]   host_addr_i,
  input  logic [XLEN-1:0]   host_wr_data_i,
  input  logic [XLEN/8-1:0] host_wr_byte_en_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [XLEN-1:0]   rd_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [XLEN-1:0]   wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic [XLEN/8-1:0] wr_byte_en_i
);

  localparam int NBYTE = XLEN / 8;
  localparam int OFF_W = $clog2(NBYTE);
  localparam int ROWS  = 2 ** ROW_BITS;
  localparam int REG_W = OFF_W + ROW_BITS;  // log2 of the region size in bytes

  // Bank index arithmetic: the result wraps modulo NBYTE because it is
  // truncated to OFF_W bits.
  function automatic logic [OFF_W-1:0] lane_sub(input int k, input logic [OFF_W-1:0] off);
    return OFF_W'(k) - off;
  endfunction

  function automatic logic [OFF_W-1:0] lane_add(input int k, input logic [OFF_W-1:0] off);
    return OFF_W'(k) + off;
  endfunction

  // The base is region aligned, so an address is in range exactly when its
  // distance from the base has no bits at or above REG_W.
  function automatic logic in_region(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] delta;
    delta = addr - XLEN'(BASE_ADDR);
    return (delta >> REG_W) == '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Request arbitration between the core and the host loader
  // ---------------------------------------------------------------------------
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [OFF_W-1:0]  rsp_off_q, rsp_off_d;

  logic              slot_free;
  logic              rd_req;
  logic              rd_acc;
  logic              wr_go;
  logic              wr_commit;
  logic [XLEN-1:0]   rd_addr;
  logic [XLEN-1:0]   wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [NBYTE-1:0]  wr_be;

  assign slot_free  = !rsp_valid_q || rsp_ready_i;
  assign rd_ready_o = !host_sel_i && slot_free;
  assign wr_ready_o = !host_sel_i;

  assign rd_addr = host_sel_i ? host_addr_i       : rd_addr_i;
  assign wr_addr = host_sel_i ? host_addr_i       : wr_addr_i;
  assign wr_data = host_sel_i ? host_wr_data_i    : wr_data_i;
  assign wr_be   = host_sel_i ? host_wr_byte_en_i : wr_byte_en_i;

  // A host read is not gated by any valid signal. It is issued whenever the
  // host presents zero byte enables and the response slot is free.
  assign rd_req    = host_sel_i ? (host_wr_byte_en_i == '0) : rd_valid_i;
  assign rd_acc    = rd_req && slot_free;
  assign wr_go     = host_sel_i ? (host_wr_byte_en_i != '0) : wr_valid_i;
  assign wr_commit = wr_go && in_region(wr_addr);

  // ---------------------------------------------------------------------------
  // Address decode: row A and row A+1 for each path
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]    rd_off, wr_off;
  logic [ROW_BITS-1:0] rd_row_a, rd_row_b, wr_row_a, wr_row_b;

  assign rd_off   = rd_addr[OFF_W-1:0];
  assign wr_off   = wr_addr[OFF_W-1:0];
  assign rd_row_a = rd_addr[REG_W-1:OFF_W];
  assign wr_row_a = wr_addr[REG_W-1:OFF_W];
  assign rd_row_b = rd_row_a + 1'b1;  // wraps from the top row to row 0
  assign wr_row_b = wr_row_a + 1'b1;

  logic [ROW_BITS-1:0] rd_row     [NBYTE];
  logic [ROW_BITS-1:0] wr_row     [NBYTE];
  logic [7:0]          wr_bytes   [NBYTE];
  logic [7:0]          wr_lane    [NBYTE];
  logic [NBYTE-1:0]    wr_lane_en;

  // NOTE: every output of an always_comb gets a value on every path (here
  // each array element is assigned on each loop pass) so no latch is inferred.
  always_comb begin
    for (int k = 0; k < NBYTE; k++) begin
      wr_bytes[k] = wr_data[8*k +: 8];
    end
    for (int k = 0; k < NBYTE; k++) begin
      rd_row[k]     = (OFF_W'(k) < rd_off) ? rd_row_b : rd_row_a;
      wr_row[k]     = (OFF_W'(k) < wr_off) ? wr_row_b : wr_row_a;
      // Bank k stores write byte (k - off) mod NBYTE and uses its enable.
      wr_lane[k]    = wr_bytes[lane_sub(k, wr_off)];
      wr_lane_en[k] = wr_commit && wr_be[lane_sub(k, wr_off)];
    end
  end

  // ---------------------------------------------------------------------------
  // Bank storage and registered read lanes
  // ---------------------------------------------------------------------------
  logic [7:0] mem_q     [NBYTE][ROWS];
  logic [7:0] rd_lane_q [NBYTE];

  // NOTE: the storage array and the read-lane registers are deliberately not
  // reset. This lets the memory map onto RAM. Stale lane data is never visible
  // because rsp_data_o is gated by rsp_valid_q.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NBYTE; k++) begin
      if (wr_lane_en[k]) begin
        mem_q[k][wr_row[k]] <= wr_lane[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NBYTE; k++) begin
      if (rd_acc) begin
`ifdef BANKED_RAM_FWD_EN
        // The same bank and row are written this cycle: bypass the new byte.
        if (wr_lane_en[k] && (wr_row[k] == rd_row[k])) begin
          rd_lane_q[k] <= wr_lane[k];
        end else begin
          rd_lane_q[k] <= mem_q[k][rd_row[k]];
        end
`else
        rd_lane_q[k] <= mem_q[k][rd_row[k]];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response slot
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = rd_acc || (rsp_valid_q && !rsp_ready_i);
    rsp_err_d   = rsp_err_q;
    rsp_off_d   = rsp_off_q;
    if (rd_acc) begin
      rsp_err_d = !in_region(rd_addr);
      rsp_off_d = rd_off;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // its pre-edge inputs regardless of the order in which the processes run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_off_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_off_q   <= rsp_off_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_valid_q && rsp_err_q;

  // Rotate the bank lanes back into address order: result byte j comes from
  // bank (off + j) mod NBYTE. The output is zero for errors and idle slots.
  always_comb begin
    rsp_data_o = '0;
    if (rsp_valid_q && !rsp_err_q) begin
      for (int j = 0; j < NBYTE; j++) begin
        rsp_data_o[8*j +: 8] = rd_lane_q[lane_add(j, rsp_off_q)];
      end
    end
  end

endmodule

// File: tb/tb_banked_ram.sv
// -----------------------------------------------------------------------------
// tb_banked_ram
//
// Bench for banked_ram with XLEN=32 and ROW_BITS=2. The region is 16 bytes, so
// row wrap and out-of-range addresses occur often under random stimulus.
//
// The reference model treats the region as a flat byte array. Byte j of an
// access at address a lives at (a - BASE + j) mod REGION. A colliding read sees
// the array before the write, or after it when BANKED_RAM_FWD_EN is defined.
// The model advances on each rising edge using only the bench's own inputs.
// A compare process checks every DUT output against the model on each falling
// edge. Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_banked_ram;

  localparam int          XLEN     = 32;
  localparam int          NBYTE    = 4;
  localparam int          ROW_BITS = 2;
  localparam int          REGION   = NBYTE << ROW_BITS;
  localparam logic [31:0] BASE     = 32'h1000_0000;

  logic              clk;
  logic              rst;
  logic              host_sel;
  logic [XLEN-1:0]   host_addr;
  logic [XLEN-1:0]   host_wdata;
  logic [NBYTE-1:0]  host_be;
  logic              rd_valid;
  logic              rd_ready;
  logic [XLEN-1:0]   rd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;
  logic              wr_valid;
  logic              wr_ready;
  logic [XLEN-1:0]   wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [NBYTE-1:0]  wr_be;

  banked_ram #(
    .XLEN      (XLEN),
    .ROW_BITS  (ROW_BITS),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .host_sel_i        (host_sel),
    .host_addr_i       (host_addr),
    .host_wr_data_i    (host_wdata),
    .host_wr_byte_en_i (host_be),
    .rd_valid_i        (rd_valid),
    .rd_ready_o        (rd_ready),
    .rd_addr_i         (rd_addr),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_data_o        (rsp_data),
    .rsp_err_o         (rsp_err),
    .wr_valid_i        (wr_valid),
    .wr_ready_o        (wr_ready),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data),
    .wr_byte_en_i      (wr_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: flat byte array plus a one-entry response slot
  // ---------------------------------------------------------------------------
  logic [7:0]  ref_mem [REGION];
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_data;

  function automatic logic in_rng(input logic [31:0] a);
    return (a - BASE) < 32'(REGION);
  endfunction

  function automatic int byte_idx(input logic [31:0] a, input int j);
    return int'((a - BASE + 32'(j)) % 32'(REGION));
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (in_rng(a)) begin
      for (int j = 0; j < NBYTE; j++) begin
        if (be[j]) ref_mem[byte_idx(a, j)] = d[8*j +: 8];
      end
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    d = '0;
    e = !in_rng(a);
    if (!e) begin
      for (int j = 0; j < NBYTE; j++) d[8*j +: 8] = ref_mem[byte_idx(a, j)];
    end
  endtask

  initial begin
    logic [31:0] ra, wa, wd, rdat;
    logic [3:0]  wbe;
    logic        rreq, acc, wgo, rerr;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_data  = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
      end else begin
        ra   = host_sel ? host_addr  : rd_addr;
        wa   = host_sel ? host_addr  : wr_addr;
        wd   = host_sel ? host_wdata : wr_data;
        wbe  = host_sel ? host_be    : wr_be;
        rreq = host_sel ? (host_be == 4'h0) : rd_valid;
        wgo  = host_sel ? (host_be != 4'h0) : wr_valid;
        acc  = rreq && (!m_valid || rsp_ready);
`ifdef BANKED_RAM_FWD_EN
        if (wgo) model_write(wa, wd, wbe);
        model_read(ra, rdat, rerr);
`else
        model_read(ra, rdat, rerr);
        if (wgo) model_write(wa, wd, wbe);
`endif
        if (acc) begin
          m_valid = 1'b1;
          m_err   = rerr;
          m_data  = rdat;
        end else if (rsp_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare process: every output, on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("rsp_valid", rsp_valid, m_valid);
      check("rsp_err",   rsp_err,   m_valid && m_err);
      check("rsp_data",  rsp_data,  m_valid ? m_data : 32'h0);
      check("rd_ready",  rd_ready,  !host_sel && (!m_valid || rsp_ready));
      check("wr_ready",  wr_ready,  !host_sel);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic core_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    check("rd_ready_before_read", rd_ready, 1'b1);
    rd_valid = 1'b1;
    rd_addr  = a;
    cyc();
    rd_valid = 1'b0;
    check("rd_latency_one_cycle", rsp_valid, 1'b1);
    d = rsp_data;
    e = rsp_err;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 31));
    if (r < 24) return BASE + 32'(r) - 32'd4;   // in range and just around it
    if (r < 28) return BASE + 32'h100 + 32'(r);
    return $urandom;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed sequences followed by random traffic
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d, hw;
    logic        e;
    rst        = 1'b1;
    host_sel   = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    host_be    = '0;
    rd_valid   = 1'b0;
    rd_addr    = '0;
    rsp_ready  = 1'b1;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_be      = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_err",   rsp_err,   1'b0);
    check("reset_rsp_data",  rsp_data,  32'h0);
    check("reset_rd_ready",  rd_ready,  1'b1);
    check("reset_wr_ready",  wr_ready,  1'b1);
    cyc();

    // Host loader fills byte i with 0x10 + i.
    host_sel = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) hw[8*b +: 8] = 8'h10 + 8'(4*w + b);
      host_addr  = BASE + 32'(4*w);
      host_wdata = hw;
      host_be    = 4'hF;
      cyc();
    end
    host_be   = 4'h0;
    host_addr = BASE + 32'd5;
    cyc();
    check("host_read_valid", rsp_valid, 1'b1);
    check("host_read_data",  rsp_data,  32'h1817_1615);
    check("host_core_stall", rd_ready,  1'b0);
    host_sel = 1'b0;
    cyc();

    // Aligned round trip.
    core_write(BASE, 32'hDEAD_BEEF, 4'hF);
    core_read(BASE, d, e);
    check("aligned_data", d, 32'hDEAD_BEEF);
    check("aligned_err",  e, 1'b0);

    // Unaligned split write across rows 0 and 1.
    core_write(BASE + 32'd3, 32'h1122_3344, 4'hF);
    core_read(BASE, d, e);
    check("split_low_row", d, 32'h44AD_BEEF);
    core_read(BASE + 32'd4, d, e);
    check("split_high_row", d, 32'h1711_2233);

    // Write at the last byte wraps from the top row to row 0.
    core_write(BASE + 32'd15, 32'hA1B2_C3D4, 4'hF);
    core_read(BASE, d, e);
    check("wrap_row0", d, 32'h44A1_B2C3);
    core_read(BASE + 32'd12, d, e);
    check("wrap_top_row", d, 32'hD41E_1D1C);
    core_read(BASE + 32'd15, d, e);
    check("wrap_read", d, 32'hA1B2_C3D4);

    // Out of range read and write.
    core_read(32'h2000_0000, d, e);
    check("oor_err",  e, 1'b1);
    check("oor_data", d, 32'h0);
    core_write(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
    core_read(BASE, d, e);
    check("oor_write_discarded", d, 32'h44A1_B2C3);
    cyc();

    // Backpressure: the first response holds while two more reads wait.
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = BASE;
    cyc();
    check("bp_first_valid", rsp_valid, 1'b1);
    check("bp_first_data",  rsp_data,  32'h44A1_B2C3);
    rd_addr = BASE + 32'd4;
    for (int i = 0; i < 3; i++) begin
      check("bp_rd_ready_low", rd_ready, 1'b0);
      cyc();
      check("bp_hold_data", rsp_data, 32'h44A1_B2C3);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rd_ready_high", rd_ready, 1'b1);
    cyc();
    check("bp_second_data", rsp_data, 32'h1711_2233);
    rd_addr = BASE + 32'd8;
    cyc();
    check("bp_third_data", rsp_data, 32'h1B1A_1918);
    rd_valid = 1'b0;
    cyc();
    check("bp_drained", rsp_valid, 1'b0);

    // Same-cycle write and read of byte 0 whose old value is 0x00.
    core_write(BASE, 32'h0, 4'h1);
    wr_valid = 1'b1;
    wr_addr  = BASE;
    wr_data  = 32'h55;
    wr_be    = 4'h1;
    rd_valid = 1'b1;
    rd_addr  = BASE;
    cyc();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
`ifdef BANKED_RAM_FWD_EN
    check("collision_forwarded", rsp_data, 32'h44A1_B255);
`else
    check("collision_old_data", rsp_data, 32'h44A1_B200);
`endif
    cyc();
    core_read(BASE, d, e);
    check("collision_after", d, 32'h44A1_B255);
    cyc();

    // Reset drops a pending response but keeps memory.
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = BASE + 32'd4;
    cyc();
    rd_valid = 1'b0;
    check("rst_pending_valid", rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_drops_valid", rsp_valid, 1'b0);
    check("rst_clears_data", rsp_data,  32'h0);
    cyc();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    core_read(BASE + 32'd4, d, e);
    check("rst_mem_kept_hi", d, 32'h1711_2233);
    core_read(BASE, d, e);
    check("rst_mem_kept_lo", d, 32'h44A1_B255);
    cyc();

    // Random traffic, host mode toggling, backpressure and collisions.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) host_sel = !host_sel;
      rd_valid   = 1'($urandom_range(0, 1));
      rd_addr    = rand_addr();
      wr_valid   = 1'($urandom_range(0, 1));
      wr_addr    = rand_addr();
      wr_data    = $urandom;
      wr_be      = 4'($urandom);
      host_addr  = rand_addr();
      host_wdata = $urandom;
      host_be    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      cyc();
    end

    host_sel  = 1'b0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    host_be   = 4'h0;
    rsp_ready = 1'b1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised byte-lane banked RAM that supports unaligned word access. Successor to the fixed 32-bit iram/dram banking.
- Made of NBYTE = XLEN/8 byte-wide banks, inferred internally. No vendor IP.
- Each access has one row pointer A, and banks below the byte offset use row A+1. This splits unaligned accesses across rows.
- Adds valid/ready handshakes, registered read responses with backpressure, address-range checking with error reporting, and host-loader override. It sits between the core load/store unit and the bus.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64; NBYTE = XLEN/8.
- ROW_BITS, 12, rows per bank = 2**ROW_BITS; region size = NBYTE*2**ROW_BITS bytes.
- BASE_ADDR, 32'h1000_0000, region base; aligned to the region size.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- host_sel_i  in  1  host loader owns both ports when high
- host_addr_i  in  XLEN  host byte address
- host_wr_data_i  in  XLEN  host write data
- host_wr_byte_en_i  in  NBYTE  host byte enables; all zero means host read
- rd_valid_i  in  1  core read request
- rd_ready_o  out  1  read request accepted
- rd_addr_i  in  XLEN  read byte address, any alignment
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  XLEN  response data, byte 0 = byte at rd_addr
- rsp_err_o  out  1  response was out of range
- wr_valid_i  in  1  core write request
- wr_ready_o  out  1  write accepted
- wr_addr_i  in  XLEN  write byte address, any alignment
- wr_data_i  in  XLEN  write data, byte 0 goes to wr_addr
- wr_byte_en_i  in  NBYTE  byte enables relative to wr_addr

Behaviour:
- Reset values: rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0. Memory contents are not reset. A pending response is dropped on reset.
- Address decode:
  - off = addr[log2(NBYTE)-1:0].
  - row A = addr[log2(NBYTE)+ROW_BITS-1:log2(NBYTE)].
  - Bank k uses row A+1 when k<off, otherwise row A.
  - A+1 wraps modulo 2**ROW_BITS, so the top row wraps to row 0.
- Byte rotation:
  - On read, result byte j comes from bank (off+j) mod NBYTE.
  - On write, bank k takes byte (k-off) mod NBYTE and its enable from the same index.
- In range: (addr - BASE_ADDR) < region size. All bytes of a wrapping access count as in range.
- Read handshake:
  - rd_ready_o = !host_sel_i && (!rsp_valid_o || rsp_ready_i).
  - Accept occurs when rd_valid_i && rd_ready_o.
  - rsp_valid_o rises on the next cycle, giving one cycle of latency.
  - off and the range flag are registered at accept.
  - While rsp_valid_o && !rsp_ready_i, banks are not read and rsp_data_o/rsp_err_o stay stable.
  - Back-to-back accepts give one response per cycle.
- Out-of-range read: rsp_err_o=1 and rsp_data_o=0. Out-of-range write is accepted and discarded.
- Write handshake:
  - wr_ready_o = !host_sel_i.
  - A write commits on the cycle it is accepted. All enabled bytes commit in the same cycle, including both rows of a split write.
- Read and write in the same cycle to the same bank and row: the read returns old data, unless the forwarding feature is compiled in.
- Host mode (host_sel_i=1):
  - Core ports are stalled.
  - Host address drives both the read and write paths.
  - A host write commits like a core write.
  - A host read (byte enables all zero) produces a response on rsp_* using the same handshake. It is not gated by rd_valid_i: it is issued every cycle the response slot is free.
- If host_sel_i toggles while a response is pending, the response is still delivered unchanged.
- rsp_data_o is forced to 0 whenever rsp_valid_o=0.

Optional Feature:
- Macro: BANKED_RAM_FWD_EN.
- Defined: read-during-write collisions forward new data, per byte. Each read byte whose bank and row are written in the same cycle returns the new write byte, selected through the write byte enables. The bypass is registered with the read.
- Undefined: read-during-write returns the old memory contents, with no bypass logic.

Test Plan:
- Aligned round trip, XLEN=32:
  - Stimulus: write 0x1000_0000 ← 0xDEADBEEF with byte enables 4'hF, then read 0x1000_0000.
  - Required: rsp_valid_o one cycle after accept, rsp_data_o=0xDEADBEEF, rsp_err_o=0.
- Unaligned split write:
  - Stimulus: write 0x1000_0003 ← 0x11223344 with byte enables 4'hF.
  - Required: read 0x1000_0000 returns 0x44xxxxxx; read 0x1000_0004 returns 0xxx112233.
- Row wrap, ROW_BITS=2:
  - Stimulus: write at byte address BASE+15 with data 0xA1B2C3D4.
  - Required: byte 0xD4 lands at BASE+15; bytes 0xC3B2A1 land at BASE+0..2.
- Backpressure:
  - Stimulus: issue 3 reads while rsp_ready_i=0.
  - Required: first response holds stable; rd_ready_o=0 until rsp_ready_i=1; then remaining responses arrive in order, one per cycle.
- Out of range:
  - Stimulus: read 0x2000_0000, then write there.
  - Required: rsp_err_o=1 and rsp_data_o=0; memory is unchanged.
- Collision and reset:
  - Stimulus: same-cycle write 0x55 to byte 0 and read of 0x1000_0000, where old data is 0x00.
  - Required: result byte 0 = 0x55 with BANKED_RAM_FWD_EN, 0x00 without it.
  - Then assert rst_i while rsp_valid_o=1: rsp_valid_o drops to 0 immediately and memory keeps its data.
